// File: rtl/simple_cpu_pkg.sv
// Shared definitions for simple_cpu_v2: instruction classes, ALU function codes,
// controller states and instruction field offsets.
package simple_cpu_pkg;

    typedef enum logic [1:0] {
        CLS_NOP   = 2'b00,
        CLS_ALU   = 2'b01,
        CLS_LOAD  = 2'b10,
        CLS_STORE = 2'b11
    } instr_class_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    localparam int CLASS_BITS = 2;
    localparam int FUNC_BITS  = 4;

    localparam logic [FUNC_BITS-1:0] FUNC_ADD = 4'd0;
    localparam logic [FUNC_BITS-1:0] FUNC_SUB = 4'd1;
    localparam logic [FUNC_BITS-1:0] FUNC_AND = 4'd2;
    localparam logic [FUNC_BITS-1:0] FUNC_OR  = 4'd3;
    localparam logic [FUNC_BITS-1:0] FUNC_XOR = 4'd4;

    // Field layout, MSB first: class | X1 | X2 | X3 | imm | func
    localparam int FUNC_LSB = 0;
    localparam int IMM_LSB  = FUNC_LSB + FUNC_BITS;

    function automatic int x3_lsb(input int data_width);
        return IMM_LSB + data_width;
    endfunction

    function automatic int x2_lsb(input int data_width, input int reg_bits);
        return IMM_LSB + data_width + reg_bits;
    endfunction

    function automatic int x1_lsb(input int data_width, input int reg_bits);
        return IMM_LSB + data_width + 2 * reg_bits;
    endfunction

    function automatic int class_lsb(input int data_width, input int reg_bits);
        return IMM_LSB + data_width + 3 * reg_bits;
    endfunction

    function automatic int instr_width(input int data_width, input int reg_bits);
        return CLASS_BITS + FUNC_BITS + 3 * reg_bits + data_width;
    endfunction

endpackage

// File: rtl/simple_cpu_alu.sv
// Combinational ALU for simple_cpu_v2. AND/OR/XOR exist only when
// SIMPLE_CPU_LOGIC_EN is defined; otherwise those codes report illegal.
module simple_cpu_alu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [FUNC_BITS-1:0]  func,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  zero,
    output logic                  illegal
);

    // SUB reports a borrow in carry, logic ops always clear it
    always_comb begin
        result  = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (func)
            FUNC_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            FUNC_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
`ifdef SIMPLE_CPU_LOGIC_EN
            FUNC_AND: result = a & b;
            FUNC_OR:  result = a | b;
            FUNC_XOR: result = a ^ b;
`endif
            default:  illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/simple_cpu_v2.sv
// Multi-cycle CPU: register file, data memory, controller FSM and handshake.
// Optional logic ops are enabled by SIMPLE_CPU_LOGIC_EN (decoded in simple_cpu_alu).
module simple_cpu_v2
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int NUM_REGS    = 4,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [INSTR_WIDTH-1:0]       instruction,
    output logic                         done,
    output logic                         illegal,
    output logic                         zero_flag,
    output logic                         carry_flag,
    input  logic [$clog2(NUM_REGS)-1:0]  dbg_sel,
    output logic [DATA_WIDTH-1:0]        dbg_data
);

    localparam int REG_BITS  = $clog2(NUM_REGS);
    localparam int MEM_DEPTH = 2 ** ADDR_BITS;
    localparam int X3_LSB    = x3_lsb(DATA_WIDTH);
    localparam int X2_LSB    = x2_lsb(DATA_WIDTH, REG_BITS);
    localparam int X1_LSB    = x1_lsb(DATA_WIDTH, REG_BITS);
    localparam int CLS_LSB   = class_lsb(DATA_WIDTH, REG_BITS);

    if (INSTR_WIDTH != instr_width(DATA_WIDTH, REG_BITS)) begin : g_bad_width
        $fatal(1, "simple_cpu_v2: INSTR_WIDTH must be 6 + 3*REG_BITS + DATA_WIDTH");
    end
    if (NUM_REGS < 2 || (1 << REG_BITS) != NUM_REGS) begin : g_bad_regs
        $fatal(1, "simple_cpu_v2: NUM_REGS must be a power of 2 and at least 2");
    end

    state_e                   state, state_next;
    logic [INSTR_WIDTH-1:0]   ir;
    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]    mem  [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]    opa, opb, mdr;
    logic                     ill_q;

    instr_class_e             cls;
    logic [REG_BITS-1:0]      x1, x2, x3;
    logic [DATA_WIDTH-1:0]    imm;
    logic [FUNC_BITS-1:0]     func;
    logic [ADDR_BITS-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic                     alu_carry, alu_zero, alu_illegal;

    assign cls  = instr_class_e'(ir[CLS_LSB +: CLASS_BITS]);
    assign x1   = ir[X1_LSB +: REG_BITS];
    assign x2   = ir[X2_LSB +: REG_BITS];
    assign x3   = ir[X3_LSB +: REG_BITS];
    assign imm  = ir[IMM_LSB +: DATA_WIDTH];
    assign func = ir[FUNC_LSB +: FUNC_BITS];

    // The sum is one bit wider than the data so a carry never aliases before truncation
    assign mem_addr = ADDR_BITS'({1'b0, opa} + {1'b0, imm});

    assign instr_ready = (state == S_IDLE);
    assign dbg_data    = regs[dbg_sel];

    simple_cpu_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a       (opa),
        .b       (opb),
        .func    (func),
        .result  (alu_result),
        .carry   (alu_carry),
        .zero    (alu_zero),
        .illegal (alu_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOP and illegal ALU codes skip straight from DECODE to WB
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (instr_valid) state_next = S_DECODE;
            S_DECODE: begin
                if (cls == CLS_LOAD || cls == CLS_STORE || (cls == CLS_ALU && !alu_illegal)) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_WB;
                end
            end
            S_EXEC:   state_next = (cls == CLS_ALU) ? S_WB : S_MEM;
            S_MEM:    state_next = S_WB;
            S_WB:     state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir         <= '0;
            opa        <= '0;
            opb        <= '0;
            mdr        <= '0;
            ill_q      <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_WIDTH'(i);
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: if (instr_valid) ir <= instruction;
                S_DECODE: begin
                    opa   <= regs[x2];
                    opb   <= (cls == CLS_STORE) ? regs[x1] : regs[x3];
                    ill_q <= (cls == CLS_ALU) && alu_illegal;
                end
                S_MEM: begin
                    if (cls == CLS_LOAD) mdr <= mem[mem_addr];
                    else mem[mem_addr] <= opb;
                end
                S_WB: begin
                    done    <= 1'b1;
                    illegal <= ill_q;
                    if (cls == CLS_ALU && !ill_q) begin
                        regs[x1]   <= alu_result;
                        zero_flag  <= alu_zero;
                        carry_flag <= alu_carry;
                    end else if (cls == CLS_LOAD) begin
                        regs[x1] <= mdr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_cpu_v2.sv
// Directed self-checking bench for simple_cpu_v2 (default parameters).
// Expectations for func 2 follow SIMPLE_CPU_LOGIC_EN as defined for the build.
module tb_simple_cpu_v2;

    localparam logic [1:0] C_NOP = 2'b00, C_ALU = 2'b01, C_LD = 2'b10, C_ST = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [19:0] instruction = '0;
    logic        done, illegal, zero_flag, carry_flag;
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;

    int vectors = 0;
    int miscompares = 0;

    int         edges;
    logic       ill, pulse_after;
    logic [7:0] val;

    simple_cpu_v2 dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .done        (done),
        .illegal     (illegal),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [19:0] enc(input logic [1:0] c, input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] d, input logic [7:0] imm, input logic [3:0] f);
        return {c, a, b, d, imm, f};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [7:0] v);
        dbg_sel = r;
        #1;
        v = dbg_data;
    endtask

    // Returns the edge count (accept edge = 1) at which done was seen, 99 on timeout
    task automatic wait_done(output int e, output logic il, output logic after);
        e = 99;
        il = 1'b0;
        after = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                e = k;
                il = illegal;
                break;
            end
            @(posedge clk);
        end
        if (e != 99) begin
            @(negedge clk);
            after = done;
        end
    endtask

    task automatic issue(input logic [19:0] w, output int e, output logic il, output logic after);
        @(negedge clk);
        instruction = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instruction = 20'hFFFFF;
        wait_done(e, il, after);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", instr_ready); end
        vectors++; if (done !== 1'b0 || illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pulses: got done=%b illegal=%b want 0/0", done, illegal); end
        vectors++; if ({zero_flag, carry_flag} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_flags: got %b%b want 00", zero_flag, carry_flag); end
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), val);
            vectors++; if (val !== 8'(r)) begin miscompares++; $display("[TB] FAIL reset_reg%0d: got %0h want %0h", r, val, r); end
        end
    endtask

    task automatic test_add();
        do_reset();
        issue(20'b01_00_01_11_00000000_0000, edges, ill, pulse_after);
        vectors++; if (edges !== 4) begin miscompares++; $display("[TB] FAIL add_latency: got %0d edges want 4", edges); end
        vectors++; if (ill !== 1'b0) begin miscompares++; $display("[TB] FAIL add_illegal: got %b want 0", ill); end
        vectors++; if (pulse_after !== 1'b0) begin miscompares++; $display("[TB] FAIL add_done_width: done still %b a cycle later, want 0", pulse_after); end
        read_reg(2'd0, val);
        vectors++; if (val !== 8'd4) begin miscompares++; $display("[TB] FAIL add_r0: got %0h want 4", val); end
        vectors++; if ({zero_flag, carry_flag} !== 2'b00) begin miscompares++; $display("[TB] FAIL add_flags: got zc=%b%b want 00", zero_flag, carry_flag); end
    endtask

    task automatic test_sub();
        do_reset();
        issue(enc(C_ALU, 2'd0, 2'd1, 2'd3, 8'd0, 4'd1), edges, ill, pulse_after);
        read_reg(2'd0, val);
        vectors++; if (val !== 8'hFE) begin miscompares++; $display("[TB] FAIL sub_r0: got %0h want fe", val); end
        vectors++; if ({zero_flag, carry_flag} !== 2'b01) begin miscompares++; $display("[TB] FAIL sub_borrow_flags: got zc=%b%b want 01", zero_flag, carry_flag); end
        issue(enc(C_ALU, 2'd2, 2'd2, 2'd2, 8'd0, 4'd1), edges, ill, pulse_after);
        read_reg(2'd2, val);
        vectors++; if (val !== 8'h00) begin miscompares++; $display("[TB] FAIL sub_self_r2: got %0h want 0", val); end
        vectors++; if ({zero_flag, carry_flag} !== 2'b10) begin miscompares++; $display("[TB] FAIL sub_self_flags: got zc=%b%b want 10", zero_flag, carry_flag); end
    endtask

    task automatic test_load_store();
        do_reset();
        issue(enc(C_ALU, 2'd0, 2'd1, 2'd3, 8'd0, 4'd1), edges, ill, pulse_after);
        issue(enc(C_ST, 2'd1, 2'd2, 2'd0, 8'd15, 4'd0), edges, ill, pulse_after);
        vectors++; if (edges !== 5) begin miscompares++; $display("[TB] FAIL store_latency: got %0d edges want 5", edges); end
        issue(enc(C_LD, 2'd3, 2'd2, 2'd0, 8'd15, 4'd0), edges, ill, pulse_after);
        vectors++; if (edges !== 5) begin miscompares++; $display("[TB] FAIL load_latency: got %0d edges want 5", edges); end
        read_reg(2'd3, val);
        vectors++; if (val !== 8'd1) begin miscompares++; $display("[TB] FAIL load_r3: got %0h want 1", val); end
        read_reg(2'd1, val);
        vectors++; if (val !== 8'd1) begin miscompares++; $display("[TB] FAIL store_keeps_r1: got %0h want 1", val); end
        vectors++; if ({zero_flag, carry_flag} !== 2'b01) begin miscompares++; $display("[TB] FAIL ldst_flags_kept: got zc=%b%b want 01", zero_flag, carry_flag); end
    endtask

    task automatic test_wrap();
        do_reset();
        issue(enc(C_ST, 2'd2, 2'd3, 2'd0, 8'd30, 4'd0), edges, ill, pulse_after);
        issue(enc(C_LD, 2'd1, 2'd0, 2'd0, 8'd1, 4'd0), edges, ill, pulse_after);
        read_reg(2'd1, val);
        vectors++; if (val !== 8'd2) begin miscompares++; $display("[TB] FAIL wrap_r1: got %0h want 2", val); end
        issue(enc(C_ST, 2'd3, 2'd3, 2'd0, 8'd255, 4'd0), edges, ill, pulse_after);
        issue(enc(C_LD, 2'd0, 2'd2, 2'd0, 8'd0, 4'd0), edges, ill, pulse_after);
        read_reg(2'd0, val);
        vectors++; if (val !== 8'd3) begin miscompares++; $display("[TB] FAIL wrap_carry_r0: got %0h want 3", val); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        instruction = enc(C_ALU, 2'd0, 2'd1, 2'd3, 8'd0, 4'd0);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instruction = enc(C_ALU, 2'd1, 2'd3, 2'd1, 8'd0, 4'd1);
        edges = 99;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                edges = k;
                break;
            end
            vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_ready_k%0d: got %b want 0", k, instr_ready); end
            @(posedge clk);
        end
        vectors++; if (edges !== 4) begin miscompares++; $display("[TB] FAIL b2b_first_latency: got %0d want 4", edges); end
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_in_done: got %b want 1", instr_ready); end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        wait_done(edges, ill, pulse_after);
        vectors++; if (edges !== 4) begin miscompares++; $display("[TB] FAIL b2b_second_latency: got %0d want 4", edges); end
        read_reg(2'd0, val);
        vectors++; if (val !== 8'd4) begin miscompares++; $display("[TB] FAIL b2b_r0: got %0h want 4", val); end
        read_reg(2'd1, val);
        vectors++; if (val !== 8'd2) begin miscompares++; $display("[TB] FAIL b2b_r1: got %0h want 2", val); end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        do_reset();
        issue(enc(C_ST, 2'd3, 2'd0, 2'd0, 8'd5, 4'd0), edges, ill, pulse_after);
        issue(enc(C_ALU, 2'd1, 2'd1, 2'd3, 8'd0, 4'd0), edges, ill, pulse_after);
        read_reg(2'd1, val);
        vectors++; if (val !== 8'd4) begin miscompares++; $display("[TB] FAIL pre_reset_r1: got %0h want 4", val); end
        @(negedge clk);
        instruction = enc(C_LD, 2'd2, 2'd0, 2'd0, 8'd5, 4'd0);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done;
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            seen = seen | done;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL midflight_done: got %b want 0", seen); end
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midflight_ready: got %b want 1", instr_ready); end
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), val);
            vectors++; if (val !== 8'(r)) begin miscompares++; $display("[TB] FAIL midflight_reg%0d: got %0h want %0h", r, val, r); end
        end
        issue(enc(C_LD, 2'd3, 2'd0, 2'd0, 8'd5, 4'd0), edges, ill, pulse_after);
        read_reg(2'd3, val);
        vectors++; if (val !== 8'd0) begin miscompares++; $display("[TB] FAIL midflight_mem_cleared: got %0h want 0", val); end
    endtask

    task automatic test_nop_illegal();
        do_reset();
        issue(enc(C_ALU, 2'd2, 2'd1, 2'd3, 8'd0, 4'd1), edges, ill, pulse_after);
        issue(enc(C_NOP, 2'd1, 2'd0, 2'd0, 8'd0, 4'd0), edges, ill, pulse_after);
        vectors++; if (edges !== 3) begin miscompares++; $display("[TB] FAIL nop_latency: got %0d want 3", edges); end
        vectors++; if (ill !== 1'b0) begin miscompares++; $display("[TB] FAIL nop_illegal: got %b want 0", ill); end
        issue(enc(C_ALU, 2'd1, 2'd2, 2'd3, 8'd0, 4'd15), edges, ill, pulse_after);
        vectors++; if (edges !== 3) begin miscompares++; $display("[TB] FAIL bad_func_latency: got %0d want 3", edges); end
        vectors++; if (ill !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_func_illegal: got %b want 1", ill); end
        vectors++; if (pulse_after !== 1'b0 || illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL bad_func_pulse_width: got done=%b illegal=%b want 0/0", pulse_after, illegal); end
        read_reg(2'd1, val);
        vectors++; if (val !== 8'd1) begin miscompares++; $display("[TB] FAIL bad_func_r1: got %0h want 1", val); end
        vectors++; if ({zero_flag, carry_flag} !== 2'b01) begin miscompares++; $display("[TB] FAIL bad_func_flags: got zc=%b%b want 01", zero_flag, carry_flag); end
    endtask

    task automatic test_logic();
        do_reset();
        issue(enc(C_ALU, 2'd2, 2'd1, 2'd3, 8'd0, 4'd1), edges, ill, pulse_after);
        issue(enc(C_ALU, 2'd0, 2'd1, 2'd3, 8'd0, 4'd2), edges, ill, pulse_after);
        read_reg(2'd0, val);
`ifdef SIMPLE_CPU_LOGIC_EN
        vectors++; if (edges !== 4 || ill !== 1'b0) begin miscompares++; $display("[TB] FAIL and_retire: got edges=%0d illegal=%b want 4/0", edges, ill); end
        vectors++; if (val !== 8'd1) begin miscompares++; $display("[TB] FAIL and_r0: got %0h want 1", val); end
        vectors++; if ({zero_flag, carry_flag} !== 2'b00) begin miscompares++; $display("[TB] FAIL and_flags: got zc=%b%b want 00", zero_flag, carry_flag); end
        issue(enc(C_ALU, 2'd1, 2'd1, 2'd3, 8'd0, 4'd4), edges, ill, pulse_after);
        read_reg(2'd1, val);
        vectors++; if (val !== 8'd2) begin miscompares++; $display("[TB] FAIL xor_r1: got %0h want 2", val); end
`else
        vectors++; if (edges !== 3 || ill !== 1'b1) begin miscompares++; $display("[TB] FAIL and_retire: got edges=%0d illegal=%b want 3/1", edges, ill); end
        vectors++; if (val !== 8'd0) begin miscompares++; $display("[TB] FAIL and_r0: got %0h want 0", val); end
        vectors++; if ({zero_flag, carry_flag} !== 2'b01) begin miscompares++; $display("[TB] FAIL and_flags: got zc=%b%b want 01", zero_flag, carry_flag); end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_load_store();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
        test_nop_illegal();
        test_logic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
